axis_parity_checker: RTL and testbench
======================================

# axis_parity_checker

Parametrised AXI-Stream packet parity checker. It accumulates the XOR of every data bit across an inbound packet on the slave port. When the packet's tlast beat is accepted, it emits a short status packet on the master port: pass or fail code, the packet's beat count, and a trailer on pass. It sits between a packet source and a status sink on the a_clk domain. Unlike the earlier single-byte tester, it uses full two-sided valid/ready handshakes, configurable width, configurable codes and selectable parity sense.

## Interface
- DATA_WIDTH, 8, width of slave and master tdata
- ODD_PARITY, 0, 0 = packet passes when total bit-XOR is 0; 1 = packet passes when it is 1
- PASS_WORD, 'hAB, first response beat on pass
- FAIL_WORD, 'hFF, first response beat on fail
- TRAILER_WORD, 'hDE, third response beat on pass
- ERR_WIDTH, 16, width of error counter
- a_clk  in  1  clock; all logic on rising edge
- axis_aresetn  in  1  reset; synchronous and active-high (despite the suffix)
- axis_s_tvalid  in  1  inbound beat valid
- axis_s_tdata  in  DATA_WIDTH  inbound data
- axis_s_tlast  in  1  inbound last beat of packet
- axis_s_tready  out  1  checker accepts inbound beat
- axis_m_tvalid  out  1  response beat valid
- axis_m_tdata  out  DATA_WIDTH  response data
- axis_m_tlast  out  1  last response beat
- axis_m_tready  in  1  sink accepts response beat
- err_cnt  out  ERR_WIDTH  failed packets since reset, saturating at all-ones
- pkt_done  out  1  one-cycle pulse on the final response-beat handshake

## Operation
- All outputs are registered. In-reset values: s_tready 0, m_tvalid 0, m_tdata 0, m_tlast 0, err_cnt 0, pkt_done 0.
- Reset also sets the FSM to RECV and clears the parity accumulator and beat counter.
- **RECV:** s_tready=1.
  - Each s_tvalid&&s_tready beat updates the accumulator: acc ^= XOR-reduce(s_tdata).
  - Each such beat increments the beat counter. The counter is DATA_WIDTH wide and saturates at 2^DATA_WIDTH-1.
  - On the tlast beat: pass = (acc_next == ODD_PARITY), where acc_next includes the tlast beat.
  - The pass result and the final count (including the tlast beat) are latched.
  - The FSM moves to RESP0. s_tready drops to 0 and m_tvalid rises to 1 with m_tdata = PASS_WORD or FAIL_WORD.
  - On fail, err_cnt increments, saturating.
- **RESP0:** holds data until m_tready. On handshake, moves to RESP1 with m_tdata = count. m_tlast = 1 on fail, 0 on pass.
- **RESP1:** on handshake:
  - fail: go to RECV (pkt_done).
  - pass: go to RESP2 with m_tdata = TRAILER_WORD and m_tlast = 1.
- **RESP2:** on handshake, go to RECV (pkt_done).
- **Return to RECV:** m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=1. Accumulator and counter are cleared.
- While m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held stable.
- No inbound beat is accepted outside RECV.
- Non-tlast beats never produce output.
- A one-beat packet (tlast on the first beat) is legal; count = 1.

## Timing
- First cycle after reset release: s_tready=1.
- Latency: the tlast handshake at edge N gives m_tvalid=1 with the status word at edge N.
- With m_tready held high, the response occupies 3 consecutive cycles on pass and 2 on fail.
- With m_tready held high, s_tready returns 1 at the edge after the last response handshake.
- Minimum packet-to-packet gap: 3 dead cycles on s_tready after a pass, 2 after a fail.
- pkt_done is high for exactly the cycle following the final response handshake.
- Reset asserted mid-packet or mid-response:
  - the next edge forces all reset values;
  - the partial packet and any pending response are discarded;
  - err_cnt returns to 0.
- s_tvalid with s_tlast while s_tready=0 is ignored; the source must hold the beat per AXIS rules.

## Test plan
- Even mode, packet 0x01,0x02,0x03 (tlast on 0x03), m_tready=1 -> response AB, 03, DE(tlast); err_cnt=0; pkt_done pulses once.
- Even mode, single beat 0x01 with tlast -> response FF, 01(tlast); err_cnt=1; s_tready back to 1 two cycles after the tlast handshake.
- Backpressure: same 3-beat pass packet with m_tready toggling 0,0,1,0,1,1 -> AB, 03, DE each held stable while stalled; no inbound beat accepted until DE is accepted.
- ODD_PARITY=1, packet 0x01 tlast -> AB, 01, DE; packet 0x03 tlast -> FF, 01(tlast), err_cnt=1.
- Saturation: 300-beat packet of 0x00 (DATA_WIDTH=8) -> AB, FF, DE; err_cnt unchanged.
- Reset for one cycle during RESP1 of a fail response -> m_tvalid=0 and err_cnt=0 next cycle; the next packet 0x0F,0xF0 gives AB, 02, DE.

Source files
------------

// File: rtl/axis_parity_checker_if.sv
// AXI-Stream style bundle: valid/data/last forward, ready backward.
// master drives tvalid/tdata/tlast and samples tready; slave is the mirror.
interface axis_parity_checker_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  tvalid;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tvalid,
      output tdata,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/axis_parity_checker.sv
// Packet parity checker: XORs every data bit of an inbound AXIS packet and,
// after tlast, sends a status packet (PASS/FAIL word, beat count, trailer).
// Ports: a_clk, axis_aresetn (sync, active-high), axis_s (slave bundle),
//        axis_m (master bundle), err_cnt (saturating fails), pkt_done (pulse).
module axis_parity_checker #(
   parameter int                    DATA_WIDTH   = 8,
   parameter bit                    ODD_PARITY   = 1'b0,
   parameter logic [DATA_WIDTH-1:0] PASS_WORD    = 'hAB,
   parameter logic [DATA_WIDTH-1:0] FAIL_WORD    = 'hFF,
   parameter logic [DATA_WIDTH-1:0] TRAILER_WORD = 'hDE,
   parameter int                    ERR_WIDTH    = 16
) (
   input  logic                     a_clk,
   input  logic                     axis_aresetn,
   axis_parity_checker_if.slave     axis_s,
   axis_parity_checker_if.master    axis_m,
   output logic [ERR_WIDTH-1:0]     err_cnt,
   output logic                     pkt_done
);

   typedef enum logic [1:0] {
      RECV,
      RESP0,
      RESP1,
      RESP2
   } state_t;

   state_t                state;
   logic                  acc;
   logic                  pass_q;
   logic [DATA_WIDTH-1:0] cnt;

   logic                  s_tready_q;
   logic                  m_tvalid_q;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic                  m_tlast_q;

   logic                  s_hs;
   logic                  m_hs;
   logic                  acc_next;
   logic [DATA_WIDTH-1:0] cnt_next;
   logic                  pass_next;

   assign axis_s.tready = s_tready_q;
   assign axis_m.tvalid = m_tvalid_q;
   assign axis_m.tdata  = m_tdata_q;
   assign axis_m.tlast  = m_tlast_q;

   // s_tready_q is only ever high in RECV, so it doubles as the state gate.
   assign s_hs = axis_s.tvalid && s_tready_q;
   assign m_hs = m_tvalid_q && axis_m.tready;

   always_comb begin
      acc_next  = acc ^ (^axis_s.tdata);
      cnt_next  = (&cnt) ? cnt : cnt + 1'b1;
      pass_next = (acc_next == ODD_PARITY);
   end

   always_ff @(posedge a_clk) begin
      if (axis_aresetn) begin
         state      <= RECV;
         acc        <= 1'b0;
         pass_q     <= 1'b0;
         cnt        <= '0;
         s_tready_q <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
         err_cnt    <= '0;
         pkt_done   <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         unique case (state)
            RECV: begin
               s_tready_q <= 1'b1;
               if (s_hs) begin
                  acc <= acc_next;
                  cnt <= cnt_next;
                  if (axis_s.tlast) begin
                     pass_q     <= pass_next;
                     state      <= RESP0;
                     s_tready_q <= 1'b0;
                     m_tvalid_q <= 1'b1;
                     m_tlast_q  <= 1'b0;
                     m_tdata_q  <= pass_next ? PASS_WORD : FAIL_WORD;
                     if (!pass_next && !(&err_cnt))
                        err_cnt <= err_cnt + 1'b1;
                  end
               end
            end
            RESP0: begin
               if (m_hs) begin
                  state     <= RESP1;
                  m_tdata_q <= cnt;
                  m_tlast_q <= !pass_q;
               end
            end
            RESP1: begin
               if (m_hs) begin
                  if (pass_q) begin
                     state     <= RESP2;
                     m_tdata_q <= TRAILER_WORD;
                     m_tlast_q <= 1'b1;
                  end else begin
                     state      <= RECV;
                     m_tvalid_q <= 1'b0;
                     m_tdata_q  <= '0;
                     m_tlast_q  <= 1'b0;
                     s_tready_q <= 1'b1;
                     acc        <= 1'b0;
                     cnt        <= '0;
                     pkt_done   <= 1'b1;
                  end
               end
            end
            RESP2: begin
               if (m_hs) begin
                  state      <= RECV;
                  m_tvalid_q <= 1'b0;
                  m_tdata_q  <= '0;
                  m_tlast_q  <= 1'b0;
                  s_tready_q <= 1'b1;
                  acc        <= 1'b0;
                  cnt        <= '0;
                  pkt_done   <= 1'b1;
               end
            end
            default: begin
               state <= RECV;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_parity_checker.sv
// Bench: even and odd parity checkers share one stimulus stream; a packet
// level model predicts each response beat, err_cnt and pkt_done pulses.
module tb_axis_parity_checker;
   localparam int DW = 8;

   logic a_clk = 1'b0;
   always #5 a_clk = ~a_clk;

   logic          rst;
   logic          s_tvalid;
   logic [DW-1:0] s_tdata;
   logic          s_tlast;
   logic          m_tready;
   logic [15:0]   err_e, err_o;
   logic          done_e, done_o;

   axis_parity_checker_if #(.DATA_WIDTH(DW)) if_se ();
   axis_parity_checker_if #(.DATA_WIDTH(DW)) if_me ();
   axis_parity_checker_if #(.DATA_WIDTH(DW)) if_so ();
   axis_parity_checker_if #(.DATA_WIDTH(DW)) if_mo ();

   assign if_se.tvalid = s_tvalid;
   assign if_se.tdata  = s_tdata;
   assign if_se.tlast  = s_tlast;
   assign if_so.tvalid = s_tvalid;
   assign if_so.tdata  = s_tdata;
   assign if_so.tlast  = s_tlast;
   assign if_me.tready = m_tready;
   assign if_mo.tready = m_tready;

   axis_parity_checker #(.DATA_WIDTH(DW), .ODD_PARITY(1'b0)) u_even (
      .a_clk        (a_clk),
      .axis_aresetn (rst),
      .axis_s       (if_se),
      .axis_m       (if_me),
      .err_cnt      (err_e),
      .pkt_done     (done_e)
   );

   axis_parity_checker #(.DATA_WIDTH(DW), .ODD_PARITY(1'b1)) u_odd (
      .a_clk        (a_clk),
      .axis_aresetn (rst),
      .axis_s       (if_so),
      .axis_m       (if_mo),
      .err_cnt      (err_o),
      .pkt_done     (done_o)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   logic [8:0] q[2][$];
   int         exp_err[2];
   int         ndone[2];
   int         npk;
   bit         pv[2], pr[2], ed[2];
   logic [8:0] pdat[2];
   bit         pat[$];
   bit         rnd_rdy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge a_clk);
      #1;
   endtask

   always @(posedge a_clk) begin
      #2;
      if (pat.size() > 0) m_tready = pat.pop_front();
      else if (rnd_rdy) m_tready = ($urandom_range(0, 2) != 0);
      else m_tready = 1'b1;
   end

   task automatic mon(input int id, input logic v, input logic [7:0] d,
                      input logic l, input logic done, input logic sr);
      logic [8:0] e;
      if (rst) begin
         pv[id] = 1'b0;
         ed[id] = 1'b0;
         return;
      end
      if (ed[id] || done)
         chk($sformatf("pkt_done%0d", id), 32'(done), 32'(ed[id]));
      if (done) ndone[id]++;
      if (pv[id] && !pr[id]) begin
         chk($sformatf("hold_valid%0d", id), 32'(v), 32'd1);
         chk($sformatf("hold_data%0d", id), 32'({l, d}), 32'(pdat[id]));
      end
      if (v) chk($sformatf("s_tready_busy%0d", id), 32'(sr), 32'd0);
      ed[id] = 1'b0;
      if (v && m_tready) begin
         if (q[id].size() == 0) begin
            chk($sformatf("unexpected_beat%0d", id), 32'({l, d}), 32'h1000);
         end else begin
            e = q[id].pop_front();
            chk($sformatf("beat%0d", id), 32'({l, d}), 32'(e));
         end
         ed[id] = l;
      end
      pv[id]   = v;
      pr[id]   = m_tready;
      pdat[id] = {l, d};
   endtask

   always @(negedge a_clk) begin
      mon(0, if_me.tvalid, if_me.tdata, if_me.tlast, done_e, if_se.tready);
      mon(1, if_mo.tvalid, if_mo.tdata, if_mo.tlast, done_o, if_so.tready);
   end

   task automatic push_resp(input int id, input bit pass, input logic [7:0] c);
      if (pass) begin
         q[id].push_back({1'b0, 8'hAB});
         q[id].push_back({1'b0, c});
         q[id].push_back({1'b1, 8'hDE});
      end else begin
         q[id].push_back({1'b0, 8'hFF});
         q[id].push_back({1'b1, c});
         exp_err[id]++;
      end
   endtask

   task automatic wait_accept();
      int t;
      for (t = 0; t < 100; t++) begin
         @(negedge a_clk);
         if (if_se.tready && if_so.tready) begin
            tick();
            return;
         end
         tick();
      end
      chk("accept_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_pkt(input logic [7:0] d[$], input bit gaps, input bit bp);
      int         n;
      logic       p;
      logic [7:0] c;
      n = d.size();
      p = 1'b0;
      foreach (d[i]) p ^= ^d[i];
      c = (n > 255) ? 8'hFF : 8'(n);
      push_resp(0, p == 1'b0, c);
      push_resp(1, p == 1'b1, c);
      npk++;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            tick();
         end
         s_tvalid = 1'b1;
         s_tdata  = d[i];
         s_tlast  = (i == n - 1);
         wait_accept();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = 8'($urandom);
      if (bp) pat = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      chk("lat_mvalid_e", 32'(if_me.tvalid), 32'd1);
      chk("lat_mvalid_o", 32'(if_mo.tvalid), 32'd1);
      chk("lat_stready_e", 32'(if_se.tready), 32'd0);
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 2000; t++) begin
         if (if_se.tready && if_so.tready && !if_me.tvalid && !if_mo.tvalid)
            break;
         tick();
      end
      if (t == 2000) chk("idle_timeout", 32'd1, 32'd0);
      chk("queue_e_empty", q[0].size(), 0);
      chk("queue_o_empty", q[1].size(), 0);
      chk("err_cnt_e", 32'(err_e), exp_err[0]);
      chk("err_cnt_o", 32'(err_o), exp_err[1]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] pk[$];
      rst = 1'b1;
      s_tvalid = 1'b0;
      s_tdata = '0;
      s_tlast = 1'b0;
      m_tready = 1'b1;
      exp_err = '{0, 0};
      ndone = '{0, 0};
      npk = 0;
      repeat (3) tick();
      chk("rst_stready_e", 32'(if_se.tready), 32'd0);
      chk("rst_mvalid_e", 32'(if_me.tvalid), 32'd0);
      chk("rst_mdata_e", 32'(if_me.tdata), 32'd0);
      chk("rst_mlast_e", 32'(if_me.tlast), 32'd0);
      chk("rst_err_e", 32'(err_e), 32'd0);
      chk("rst_done_e", 32'(done_e), 32'd0);
      chk("rst_mvalid_o", 32'(if_mo.tvalid), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_stready", 32'(if_se.tready), 32'd1);

      pk = {8'h01, 8'h02, 8'h03};
      send_pkt(pk, 1'b0, 1'b0);
      wait_idle();

      pk = {8'h01};
      send_pkt(pk, 1'b0, 1'b0);
      chk("fail_gap0", 32'(if_se.tready), 32'd0);
      tick();
      chk("fail_gap1", 32'(if_se.tready), 32'd0);
      tick();
      chk("fail_gap2", 32'(if_se.tready), 32'd1);
      wait_idle();

      pk = {8'h01, 8'h02, 8'h03};
      send_pkt(pk, 1'b0, 1'b1);
      wait_idle();

      pk = {8'h01};
      send_pkt(pk, 1'b0, 1'b0);
      wait_idle();
      pk = {8'h03};
      send_pkt(pk, 1'b0, 1'b0);
      wait_idle();

      pk = {};
      for (int i = 0; i < 300; i++) pk.push_back(8'h00);
      send_pkt(pk, 1'b0, 1'b0);
      wait_idle();
      repeat (3) tick();
      chk("ndone_e", ndone[0], npk);
      chk("ndone_o", ndone[1], npk);

      pk = {8'h01};
      send_pkt(pk, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_mvalid_e", 32'(if_me.tvalid), 32'd0);
      chk("mid_rst_err_e", 32'(err_e), 32'd0);
      chk("mid_rst_mvalid_o", 32'(if_mo.tvalid), 32'd0);
      chk("mid_rst_err_o", 32'(err_o), 32'd0);
      chk("mid_rst_done_e", 32'(done_e), 32'd0);
      rst = 1'b0;
      q[0] = {};
      q[1] = {};
      exp_err = '{0, 0};
      ndone = '{0, 0};
      npk = 0;
      tick();
      chk("mid_rst_stready", 32'(if_se.tready), 32'd1);
      pk = {8'h0F, 8'hF0};
      send_pkt(pk, 1'b0, 1'b0);
      wait_idle();

      rnd_rdy = 1'b1;
      for (int k = 0; k < 40; k++) begin
         pk = {};
         for (int i = 0; i < int'($urandom_range(1, 8)); i++)
            pk.push_back(8'($urandom));
         send_pkt(pk, 1'b1, 1'b0);
         wait_idle();
      end
      rnd_rdy = 1'b0;
      repeat (4) tick();
      chk("ndone_final_e", ndone[0], npk);
      chk("ndone_final_o", ndone[1], npk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
